// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receive and transmit paths.
//   uart_state_e     - receiver frame FSM states
//   OVERSAMPLE       - baud-timer ticks per bit (fixed, even)
//   DEFAULT_BAUD_DIV - default clk cycles per oversample tick
package uart_pkg;

  localparam int OVERSAMPLE       = 16;
  localparam int DEFAULT_BAUD_DIV = 27;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator for the UART.
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   clr  in  restart the period from zero (wins over the wrap)
//   tick out one-cycle pulse every BAUD_DIV clk cycles
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        wrap_s;

  assign wrap_s = (cnt_q == 16'(BAUD_DIV - 1));
  // A clear suppresses the tick of the same cycle so timing restarts cleanly.
  assign tick   = wrap_s & ~clr;

  // Next count: clear, wrap or increment.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clr) begin
      cnt_d = 16'd0;
    end else if (wrap_s) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Period counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive front-end with 16x oversampling.
//   clk       in  system clock, rising edge
//   rst       in  synchronous active-high reset
//   rx        in  asynchronous serial line, idle high
//   rx_data   out last received byte, LSB = first data bit on the line
//   rx_valid  out one-cycle pulse, rx_data holds a good frame
//   frame_err out one-cycle pulse, stop bit sampled low
//   busy      out high whenever the FSM is not IDLE
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [3:0] HALF_LAST = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] BIT_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] DBIT_LAST = 4'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic                 sync1_q, rxs_q, rxs_prev_q;
  logic [3:0]           samp_cnt_q, samp_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q;
  logic                 tick_s;
  logic                 clr_s;
  logic                 fall_s;

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (clr_s),
    .tick(tick_s)
  );

  // Falling edge on the synchronised line; history is kept in every state.
  assign fall_s = rxs_prev_q & ~rxs_q;

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rx;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Frame FSM next-state and datapath updates; strobes default low.
  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    clr_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_s) begin
          state_d    = START;
          samp_cnt_d = 4'd0;
          clr_s      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          if (samp_cnt_q == HALF_LAST) begin
            // Mid start bit: still low means a real start, else a glitch.
            if (!rxs_q) begin
              state_d    = DATA;
              samp_cnt_d = 4'd0;
              bit_cnt_d  = 4'd0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + 4'd1;
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          if (samp_cnt_q == BIT_LAST) begin
            // LSB arrives first, so shift right and insert at the MSB.
            shift_d    = {rxs_q, shift_q[DATA_BITS-1:1]};
            bit_cnt_d  = bit_cnt_q + 4'd1;
            samp_cnt_d = 4'd0;
            if (bit_cnt_q == DBIT_LAST) begin
              state_d = STOP;
            end else begin
              state_d = DATA;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + 4'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (tick_s) begin
          if (samp_cnt_q == BIT_LAST) begin
            data_d     = shift_q;
            samp_cnt_d = 4'd0;
            // Returning to IDLE mid stop bit lets a back-to-back start edge be seen.
            if (rxs_q) begin
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + 4'd1;
          end
        end else begin
          state_d = STOP;
        end
      end
      BREAK: begin
        // Hold off until the line is released so a long low gives one error.
        if (rxs_q) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      samp_cnt_q <= 4'd0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame at BAUD_DIV=4 (64 clk per bit), 8-bit and 7-bit instances.
module tb_uart_rx_frame;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx8, rx7;
  logic [7:0] rx_data8;
  logic       rx_valid8, frame_err8, busy8;
  logic [6:0] rx_data7;
  logic       rx_valid7, frame_err7, busy7;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  int         v8_cnt = 0, f8_cnt = 0, v7_cnt = 0, f7_cnt = 0;
  int         v8_cyc = 0, v8_prevcyc = 0, f8_cyc = 0, v7_cyc = 0, f7_cyc = 0;
  logic [7:0] v8_last = 8'h00, v8_prevd = 8'h00;
  int         overlap = 0;
  logic       prev_pulse8 = 1'b0, prev_pulse7 = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_v;
    int         exp_f;
  } vec_t;

  vec_t tbl[6];

  uart_rx_frame #(.BAUD_DIV(4), .DATA_BITS(8)) dut8 (
    .clk(clk), .rst(rst), .rx(rx8),
    .rx_data(rx_data8), .rx_valid(rx_valid8), .frame_err(frame_err8), .busy(busy8)
  );

  uart_rx_frame #(.BAUD_DIV(4), .DATA_BITS(7)) dut7 (
    .clk(clk), .rst(rst), .rx(rx7),
    .rx_data(rx_data7), .rx_valid(rx_valid7), .frame_err(frame_err7), .busy(busy7)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder; also counts strobes that coincide or follow each other directly.
  always @(negedge clk) begin
    prev_pulse8 <= rx_valid8 | frame_err8;
    prev_pulse7 <= rx_valid7 | frame_err7;
    if ((rx_valid8 & frame_err8) | ((rx_valid8 | frame_err8) & prev_pulse8) |
        (rx_valid7 & frame_err7) | ((rx_valid7 | frame_err7) & prev_pulse7))
      overlap <= overlap + 1;
    if (rx_valid8) begin
      v8_cnt     <= v8_cnt + 1;
      v8_prevd   <= v8_last;
      v8_last    <= rx_data8;
      v8_prevcyc <= v8_cyc;
      v8_cyc     <= cyc;
    end
    if (frame_err8) begin
      f8_cnt <= f8_cnt + 1;
      f8_cyc <= cyc;
    end
    if (rx_valid7) begin
      v7_cnt <= v7_cnt + 1;
      v7_cyc <= cyc;
    end
    if (frame_err7) begin
      f7_cnt <= f7_cnt + 1;
      f7_cyc <= cyc;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit sel, input logic b);
    if (sel) rx7 = b;
    else rx8 = b;
    tick_n(BIT);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input int nb, input logic stop);
    start_cyc = cyc;
    drive(sel, 1'b0);
    for (int i = 0; i < nb; i++) drive(sel, d[i]);
    drive(sel, stop);
  endtask

  initial begin
    int v0, f0;

    tbl[0] = '{data: 8'hA5, stop: 1'b1, exp_v: 1, exp_f: 0};
    tbl[1] = '{data: 8'h3C, stop: 1'b0, exp_v: 0, exp_f: 1};
    tbl[2] = '{data: 8'h00, stop: 1'b1, exp_v: 1, exp_f: 0};
    tbl[3] = '{data: 8'hFF, stop: 1'b1, exp_v: 1, exp_f: 0};
    tbl[4] = '{data: 8'h81, stop: 1'b1, exp_v: 1, exp_f: 0};
    tbl[5] = '{data: 8'h5A, stop: 1'b0, exp_v: 0, exp_f: 1};

    rx8 = 1'b1;
    rx7 = 1'b1;
    rst = 1'b1;
    tick_n(3);
    check("reset_data", int'(rx_data8), 0);
    check("reset_valid", int'(rx_valid8), 0);
    check("reset_ferr", int'(frame_err8), 0);
    check("reset_busy", int'(busy8), 0);
    rst = 1'b0;
    tick_n(10);

    // Table-driven single frames, each followed by two bit times of idle.
    for (int k = 0; k < 6; k++) begin
      v0 = v8_cnt;
      f0 = f8_cnt;
      send_frame(1'b0, tbl[k].data, 8, tbl[k].stop);
      rx8 = 1'b1;
      tick_n(2 * BIT);
      check("tbl_valid_count", v8_cnt - v0, tbl[k].exp_v);
      check("tbl_ferr_count", f8_cnt - f0, tbl[k].exp_f);
      check("tbl_rx_data", int'(rx_data8), int'(tbl[k].data));
      check("tbl_busy_after", int'(busy8), 0);
      if (tbl[k].exp_v != 0) check("tbl_valid_latency", v8_cyc - start_cyc, 611);
      else check("tbl_ferr_latency", f8_cyc - start_cyc, 611);
    end

    // Short low glitch is rejected at the mid start-bit check.
    v0 = v8_cnt;
    f0 = f8_cnt;
    start_cyc = cyc;
    rx8 = 1'b0;
    tick_n(12);
    rx8 = 1'b1;
    tick_n(8);
    check("glitch_busy_high", int'(busy8), 1);
    tick_n(20);
    check("glitch_busy_low", int'(busy8), 0);
    tick_n(3 * BIT);
    check("glitch_no_valid", v8_cnt - v0, 0);
    check("glitch_no_ferr", f8_cnt - f0, 0);

    // Bad stop bit followed by a held-low line: one error, exit only on release.
    v0 = v8_cnt;
    f0 = f8_cnt;
    send_frame(1'b0, 8'h3C, 8, 1'b0);
    tick_n(3 * BIT);
    check("break_busy_held", int'(busy8), 1);
    check("break_one_ferr", f8_cnt - f0, 1);
    check("break_no_valid", v8_cnt - v0, 0);
    check("break_rx_data", int'(rx_data8), 32'h3C);
    rx8 = 1'b1;
    tick_n(8);
    check("break_busy_released", int'(busy8), 0);
    tick_n(BIT);
    check("break_still_one_ferr", f8_cnt - f0, 1);

    // Back-to-back frames with no idle gap.
    v0 = v8_cnt;
    send_frame(1'b0, 8'h00, 8, 1'b1);
    send_frame(1'b0, 8'hFF, 8, 1'b1);
    tick_n(2 * BIT);
    check("b2b_valid_count", v8_cnt - v0, 2);
    check("b2b_first_data", int'(v8_prevd), 32'h00);
    check("b2b_second_data", int'(v8_last), 32'hFF);
    check("b2b_spacing", v8_cyc - v8_prevcyc, 640);

    // Reset during data bit 4 of 0x55 aborts the frame silently.
    v0 = v8_cnt;
    f0 = f8_cnt;
    rx8 = 1'b0;
    tick_n(BIT);
    for (int i = 0; i < 4; i++) begin
      rx8 = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick_n(BIT);
    end
    rx8 = 1'b1;
    tick_n(20);
    rst = 1'b1;
    tick_n(1);
    rst = 1'b0;
    check("rst_mid_data", int'(rx_data8), 0);
    check("rst_mid_valid", int'(rx_valid8), 0);
    check("rst_mid_ferr", int'(frame_err8), 0);
    check("rst_mid_busy", int'(busy8), 0);
    tick_n(12 * BIT);
    check("rst_no_valid", v8_cnt - v0, 0);
    check("rst_no_ferr", f8_cnt - f0, 0);
    send_frame(1'b0, 8'h81, 8, 1'b1);
    tick_n(2 * BIT);
    check("rst_next_valid", v8_cnt - v0, 1);
    check("rst_next_data", int'(rx_data8), 32'h81);

    // Seven-bit instance: stop sampled in the eighth bit slot.
    v0 = v7_cnt;
    f0 = f7_cnt;
    send_frame(1'b1, 8'h2A, 7, 1'b1);
    rx7 = 1'b1;
    tick_n(2 * BIT);
    check("db7_valid_count", v7_cnt - v0, 1);
    check("db7_rx_data", int'(rx_data7), 32'h2A);
    check("db7_latency", v7_cyc - start_cyc, 547);
    check("db7_busy_after", int'(busy7), 0);
    v0 = v7_cnt;
    send_frame(1'b1, 8'h2A, 7, 1'b0);
    rx7 = 1'b1;
    tick_n(2 * BIT);
    check("db7_bad_stop_ferr", f7_cnt - f0, 1);
    check("db7_bad_stop_no_valid", v7_cnt - v0, 0);
    check("db7_ferr_latency", f7_cyc - start_cyc, 547);

    check("strobe_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Receive front-end of the UART RX path; sits directly upstream of the serial-to-parallel byte consumer.
- Synchronises the raw `rx` line and runs a 16x oversampling baud timer.
- Detects and qualifies the start bit, samples each data bit at mid-bit, and checks the stop bit.
- Delivers one assembled byte with a single-cycle valid strobe, or a framing-error strobe.

Parameters:
- BAUD_DIV, 27, clk cycles per oversample tick (tick rate = 16 x baud); legal range 2..65535
- DATA_BITS, 8, data bits per frame; legal range 5..8
- OVERSAMPLE, 16, ticks per bit; fixed, must be even

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- rx  in  1  asynchronous serial line, idle high
- rx_data  out  DATA_BITS  last received byte, LSB = first data bit on the line
- rx_valid  out  1  one-cycle pulse: rx_data holds a good frame
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - rx_data=0, rx_valid=0, frame_err=0, busy=0.
  - state=IDLE; both sync flops = 1; tick and bit counters = 0.
  - rst overrides everything, including mid-frame; no pulse is emitted for an aborted frame.
- Synchroniser: 2-flop chain on `rx`. `rxs` denotes the second flop. Add 2 cycles of input latency.
- Tick generator:
  - Counter runs 0..BAUD_DIV-1; `tick` is high for one clk when the counter wraps.
  - The counter is forced to 0 on the start-edge cycle so that bit timing aligns to the edge.
- `samp_cnt` (4 bits) counts ticks within the current bit; `bit_cnt` counts data bits.
- FSM states and transitions:
  - IDLE: on falling edge (previous rxs=1, current rxs=0) -> START; clear samp_cnt and tick counter.
  - START: count ticks; at samp_cnt=OVERSAMPLE/2-1 on a tick:
    - if rxs=0 -> DATA, samp_cnt=0, bit_cnt=0;
    - else -> IDLE (glitch rejected, no strobe).
  - DATA: on each tick where samp_cnt=OVERSAMPLE-1:
    - shift rxs into the MSB of the shift register (right shift, LSB-first on the wire);
    - bit_cnt++;
    - after DATA_BITS samples -> STOP.
  - STOP: on the tick where samp_cnt=OVERSAMPLE-1, sample rxs:
    - rxs=1: rx_data <= shift reg, rx_valid=1 next cycle -> IDLE.
    - rxs=0: rx_data <= shift reg, frame_err=1 next cycle -> BREAK.
  - BREAK: wait for rxs=1, then -> IDLE. A line held low produces exactly one frame_err.
- Output rules:
  - rx_valid and frame_err are mutually exclusive and never high on consecutive cycles for the same frame.
  - rx_data is stable between strobes.
- Latency: the strobe is asserted 1 clk after the mid-stop-bit sample tick, i.e. about 9.5 bit times + 3 clk after the line falling edge (DATA_BITS=8).
- Back-to-back frames:
  - IDLE is entered mid-stop-bit, so a start edge arriving at the stop-bit end is detected.
  - The edge detector needs previous rxs=1; rxs history is updated in every state.
- No backpressure: the consumer must take rx_data within one frame time. A new frame overwrites rx_data.
- Simultaneous events:
  - rst wins over everything.
  - The tick-counter clear wins over the wrap in the edge cycle.

Decomposition:
- Shared package `uart_pkg`:
  - state enum IDLE/START/DATA/STOP/BREAK;
  - OVERSAMPLE constant;
  - DEFAULT_BAUD_DIV constant.
- One sub-module `uart_baud_tick`:
  - ports: clk, rst, clr, tick;
  - parameter: BAUD_DIV;
  - shared later with the TX path.
- Synchroniser and FSM stay inline.

Test Plan (bench uses BAUD_DIV=4, so 64 clk per bit):
- Send 0xA5 with a good stop bit -> rx_data=0xA5, rx_valid high exactly 1 cycle about 611 clk after the edge, frame_err=0, busy low after.
- Low glitch of 3 ticks (12 clk) then high -> no rx_valid, no frame_err, busy returns 0 within 8 ticks.
- Send 0x3C with stop bit forced 0, then line low for 3 bit times -> rx_data=0x3C, a single frame_err pulse, no rx_valid, IDLE only after the line returns high.
- Back-to-back 0x00 then 0xFF, with no idle gap -> two rx_valid pulses, about 640 clk apart, carrying 0x00 then 0xFF.
- Assert rst for 1 cycle during data bit 4 of 0x55, then send 0x81 -> no strobe for the aborted frame; 0x81 is received correctly; all outputs are 0 on the cycle after rst.
- DATA_BITS=7, send 0x2A -> rx_data=7'h2A, rx_valid pulse, and the stop bit is sampled at bit 8.
